// File: rtl/ac97_pkg.sv
// AC'97 link shared definitions: frame geometry, slot boundaries, slot lookup helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: frame/tag/slot widths, counter landmarks, slot-start constants,
//           ac97_slot_idx(cnt) and ac97_slot_start(idx).
package ac97_pkg;

   localparam int AC97_FRAME_BITS = 256;
   localparam int AC97_TAG_BITS   = 16;
   localparam int AC97_SLOT_BITS  = 20;
   localparam int AC97_NUM_SLOTS  = 12;

   // First counter value of each driven slot; slots 5..12 carry zeros.
   localparam logic [7:0] AC97_SLOT1_START = 8'd16;
   localparam logic [7:0] AC97_SLOT2_START = 8'd36;
   localparam logic [7:0] AC97_SLOT3_START = 8'd56;
   localparam logic [7:0] AC97_SLOT4_START = 8'd76;
   localparam logic [7:0] AC97_SLOT5_START = 8'd96;

   // Counter landmarks.
   localparam logic [7:0] AC97_CNT_RESET  = 8'd254;  // one edge before the strobe cycle
   localparam logic [7:0] AC97_CNT_STROBE = 8'd255;  // strobe / slot-latch cycle
   localparam logic [7:0] AC97_SYNC_LAST  = 8'd14;   // sync covers 255 and 0..14
   localparam logic [7:0] AC97_RX_PUBLISH = 8'd56;   // edge ending this cycle publishes status
   localparam int         AC97_RX_BITS    = 56;      // rx frame bits 0..55 are kept

   // Slot index for a counter value: 0 = tag, 1..12 = data slots.
   function automatic logic [3:0] ac97_slot_idx(input logic [7:0] cnt);
      logic [3:0] idx;
      idx = 4'd0;
      for (int n = 1; n <= AC97_NUM_SLOTS; n++) begin
         if (int'(cnt) >= AC97_TAG_BITS + AC97_SLOT_BITS * (n - 1))
            idx = 4'(n);
      end
      return idx;
   endfunction

   // First counter value of a slot index (tag starts at 0).
   function automatic logic [7:0] ac97_slot_start(input logic [3:0] idx);
      if (idx == 4'd0)
         return 8'd0;
      return 8'(AC97_TAG_BITS + AC97_SLOT_BITS * (int'(idx) - 1));
   endfunction

endpackage

// File: rtl/ac97_link_if.sv
// AC'97 link signal bundle: upstream slot/command inputs, codec serial pins, status outputs.
// Latency: n/a (wires only).
// Backpressure: none; upstream advances on ac97_strobe instead of a ready.
// Modports: slave = link engine side, master = upstream/codec side (the bench).
interface ac97_link_if;
   import ac97_pkg::*;

   logic                      ac97_strobe;
   logic [AC97_SLOT_BITS-1:0] ac97_out_slot1;
   logic                      ac97_out_slot1_valid;
   logic [AC97_SLOT_BITS-1:0] ac97_out_slot2;
   logic                      ac97_out_slot2_valid;
   logic [AC97_SLOT_BITS-1:0] ac97_out_slot3;
   logic                      ac97_out_slot3_valid;
   logic [AC97_SLOT_BITS-1:0] ac97_out_slot4;
   logic                      ac97_out_slot4_valid;
   logic                      ac97_sync;
   logic                      ac97_sdata_out;
   logic                      ac97_sdata_in;
   logic                      ac97_codec_ready;
   logic [AC97_SLOT_BITS-1:0] ac97_in_slot1;
   logic [AC97_SLOT_BITS-1:0] ac97_in_slot2;
   logic                      ac97_in_valid;

   modport slave (
      input  ac97_out_slot1, ac97_out_slot1_valid,
      input  ac97_out_slot2, ac97_out_slot2_valid,
      input  ac97_out_slot3, ac97_out_slot3_valid,
      input  ac97_out_slot4, ac97_out_slot4_valid,
      input  ac97_sdata_in,
      output ac97_strobe, ac97_sync, ac97_sdata_out,
      output ac97_codec_ready, ac97_in_slot1, ac97_in_slot2, ac97_in_valid
   );

   modport master (
      output ac97_out_slot1, ac97_out_slot1_valid,
      output ac97_out_slot2, ac97_out_slot2_valid,
      output ac97_out_slot3, ac97_out_slot3_valid,
      output ac97_out_slot4, ac97_out_slot4_valid,
      output ac97_sdata_in,
      input  ac97_strobe, ac97_sync, ac97_sdata_out,
      input  ac97_codec_ready, ac97_in_slot1, ac97_in_slot2, ac97_in_valid
   );

endinterface

// File: rtl/ac97_frame_shifter.sv
// AC'97 tx frame shifter: slot shadow registers, slot0 tag build, serial bit select.
// Latency: sdata for counter value N is registered on the edge that moves the counter to N.
// Backpressure: none; slot inputs are sampled only on the latch edge and ignored otherwise.
// Ports: ac97_bitclk/rst clock and async reset; i_latch = counter at 255; i_cnt_next = counter
//        after this edge; i_slot1..4 + i_slot_valid{1..4} slot data; o_sdata_out registered bit.
module ac97_frame_shifter
   import ac97_pkg::*;
(
   input  logic                      ac97_bitclk,
   input  logic                      rst,
   input  logic                      i_latch,
   input  logic [7:0]                i_cnt_next,
   input  logic [AC97_SLOT_BITS-1:0] i_slot1,
   input  logic [AC97_SLOT_BITS-1:0] i_slot2,
   input  logic [AC97_SLOT_BITS-1:0] i_slot3,
   input  logic [AC97_SLOT_BITS-1:0] i_slot4,
   input  logic [3:0]                i_slot_valid,   // [3]=slot1 .. [0]=slot4
   output logic                      o_sdata_out
);

   logic [AC97_SLOT_BITS-1:0] r_slot1, r_slot2, r_slot3, r_slot4;
   logic [3:0]                r_valid;
   logic                      r_sdata;

   logic [AC97_SLOT_BITS-1:0] w_slot1, w_slot2, w_slot3, w_slot4;
   logic [3:0]                w_valid;
   logic [AC97_TAG_BITS-1:0]  w_tag;
   logic [3:0]                w_idx;
   logic [7:0]                w_start;
   logic [4:0]                w_off;
   logic                      w_bit;

   always_ff @(posedge ac97_bitclk or posedge rst) begin
      if (rst) begin
         r_slot1 <= '0;
         r_slot2 <= '0;
         r_slot3 <= '0;
         r_slot4 <= '0;
         r_valid <= '0;
      end else if (i_latch) begin
         r_slot1 <= i_slot1;
         r_slot2 <= i_slot2;
         r_slot3 <= i_slot3;
         r_slot4 <= i_slot4;
         r_valid <= i_slot_valid;
      end
   end

   // The latch edge is also the edge that emits tag bit 15, so the tag for
   // that one bit must come straight from the inputs being captured.
   assign w_slot1 = i_latch ? i_slot1      : r_slot1;
   assign w_slot2 = i_latch ? i_slot2      : r_slot2;
   assign w_slot3 = i_latch ? i_slot3      : r_slot3;
   assign w_slot4 = i_latch ? i_slot4      : r_slot4;
   assign w_valid = i_latch ? i_slot_valid : r_valid;

   // Frame-valid, per-slot valids, then codec ID 00 and reserved zeros.
   assign w_tag = {|w_valid, w_valid, 11'b0};

   assign w_idx   = ac97_slot_idx(i_cnt_next);
   assign w_start = ac97_slot_start(w_idx);
   assign w_off   = 5'(i_cnt_next - w_start);

   // MSB-first within each field; slots 5..12 are not driven.
   always_comb begin
      w_bit = 1'b0;
      case (w_idx)
         4'd0:    w_bit = w_tag[4'd15 - w_off[3:0]];
         4'd1:    w_bit = w_slot1[5'd19 - w_off];
         4'd2:    w_bit = w_slot2[5'd19 - w_off];
         4'd3:    w_bit = w_slot3[5'd19 - w_off];
         4'd4:    w_bit = w_slot4[5'd19 - w_off];
         default: w_bit = 1'b0;
      endcase
   end

   always_ff @(posedge ac97_bitclk or posedge rst) begin
      if (rst)
         r_sdata <= 1'b0;
      else
         r_sdata <= w_bit;
   end

   assign o_sdata_out = r_sdata;

endmodule

// File: rtl/ac97_link.sv
// AC'97 controller link engine: 256-bit frame counter, sync/strobe, tx serialiser, rx status capture.
// Latency: inputs captured on a strobe cycle appear in the next frame; rx status publishes at cnt 57.
// Backpressure: none; upstream advances one item per ac97_strobe pulse, once per 256 bit clocks.
// Ports: ac97_bitclk clock; rst async active-high reset; bus (slave) carries slot inputs,
//        sync/sdata_out/sdata_in codec pins, strobe, codec_ready and status slot1/slot2/valid.
module ac97_link
   import ac97_pkg::*;
(
   input  logic        ac97_bitclk,
   input  logic        rst,
   ac97_link_if.slave  bus
);

   logic [7:0]                r_cnt;
   logic                      r_sync;
   logic                      r_strobe;
   logic [AC97_RX_BITS-2:0]   r_rx_sr;
   logic                      r_codec_ready;
   logic [AC97_SLOT_BITS-1:0] r_in_slot1;
   logic [AC97_SLOT_BITS-1:0] r_in_slot2;
   logic                      r_in_valid;

   logic [7:0]                w_cnt_next;
   logic                      w_latch;
   logic                      w_rx_shift;
   logic                      w_rx_publish;
   logic [AC97_RX_BITS-1:0]   w_rx_frame;
   logic                      w_sdata_out;

   assign w_cnt_next = r_cnt + 8'd1;
   assign w_latch    = (r_cnt == AC97_CNT_STROBE);

   // Frame counter plus sync/strobe, all registered from the next count so
   // they line up with the count that is current after the edge.
   always_ff @(posedge ac97_bitclk or posedge rst) begin
      if (rst) begin
         r_cnt    <= AC97_CNT_RESET;
         r_sync   <= 1'b0;
         r_strobe <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_next;
         r_strobe <= (w_cnt_next == AC97_CNT_STROBE);
         r_sync   <= (w_cnt_next == AC97_CNT_STROBE) || (w_cnt_next <= AC97_SYNC_LAST);
      end
   end

   ac97_frame_shifter u_shifter (
      .ac97_bitclk  (ac97_bitclk),
      .rst          (rst),
      .i_latch      (w_latch),
      .i_cnt_next   (w_cnt_next),
      .i_slot1      (bus.ac97_out_slot1),
      .i_slot2      (bus.ac97_out_slot2),
      .i_slot3      (bus.ac97_out_slot3),
      .i_slot4      (bus.ac97_out_slot4),
      .i_slot_valid ({bus.ac97_out_slot1_valid, bus.ac97_out_slot2_valid,
                      bus.ac97_out_slot3_valid, bus.ac97_out_slot4_valid}),
      .o_sdata_out  (w_sdata_out)
   );

   // Rx bit k is taken on the edge ending cnt == k+1, so bits 0..55 arrive on
   // the edges ending cnt 1..56. The publish edge also carries bit 55, hence the
   // frame view appends the live input to the 55 bits already shifted in.
   // In w_rx_frame, frame bit k sits at index 55-k.
   assign w_rx_shift   = (r_cnt >= 8'd1) && (r_cnt <= AC97_RX_PUBLISH);
   assign w_rx_publish = (r_cnt == AC97_RX_PUBLISH);
   assign w_rx_frame   = {r_rx_sr, bus.ac97_sdata_in};

   always_ff @(posedge ac97_bitclk or posedge rst) begin
      if (rst) begin
         r_rx_sr       <= '0;
         r_codec_ready <= 1'b0;
         r_in_slot1    <= '0;
         r_in_slot2    <= '0;
         r_in_valid    <= 1'b0;
      end else begin
         r_in_valid <= 1'b0;
         if (w_rx_shift)
            r_rx_sr <= w_rx_frame[AC97_RX_BITS-2:0];
         if (w_rx_publish) begin
            r_codec_ready <= w_rx_frame[55];
            // Status slots count only when the codec tags both as valid.
            if (w_rx_frame[54] && w_rx_frame[53]) begin
               r_in_slot1 <= w_rx_frame[39:20];   // frame bits 16..35
               r_in_slot2 <= w_rx_frame[19:0];    // frame bits 36..55
               r_in_valid <= 1'b1;
            end
         end
      end
   end

   assign bus.ac97_strobe      = r_strobe;
   assign bus.ac97_sync        = r_sync;
   assign bus.ac97_sdata_out   = w_sdata_out;
   assign bus.ac97_codec_ready = r_codec_ready;
   assign bus.ac97_in_slot1    = r_in_slot1;
   assign bus.ac97_in_slot2    = r_in_slot2;
   assign bus.ac97_in_valid    = r_in_valid;

endmodule

// File: tb/tb_ac97_link.sv
// Bench for ac97_link: directed frames, codec return model, expectation queue and monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_ac97_link;
   import ac97_pkg::*;

   localparam int K_SDATA  = 0;
   localparam int K_SYNC   = 1;
   localparam int K_STROBE = 2;
   localparam int K_RDY    = 3;
   localparam int K_S1     = 4;
   localparam int K_S2     = 5;
   localparam int K_VLD    = 6;

   typedef struct {
      int          cyc;
      int          kind;
      logic [19:0] val;
   } exp_t;

   exp_t q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic ac97_bitclk = 1'b0;
   logic rst         = 1'b1;

   ac97_link_if bus();

   ac97_link dut (
      .ac97_bitclk (ac97_bitclk),
      .rst         (rst),
      .bus         (bus)
   );

   always #5 ac97_bitclk = ~ac97_bitclk;
   always @(posedge ac97_bitclk) cyc <= cyc + 1;

   function automatic string kname(input int kind);
      case (kind)
         K_SDATA:  return "sdata_out";
         K_SYNC:   return "sync";
         K_STROBE: return "strobe";
         K_RDY:    return "codec_ready";
         K_S1:     return "in_slot1";
         K_S2:     return "in_slot2";
         K_VLD:    return "in_valid";
         default:  return "unknown";
      endcase
   endfunction

   function automatic logic [19:0] observe(input int kind);
      case (kind)
         K_SDATA:  return {19'b0, bus.ac97_sdata_out};
         K_SYNC:   return {19'b0, bus.ac97_sync};
         K_STROBE: return {19'b0, bus.ac97_strobe};
         K_RDY:    return {19'b0, bus.ac97_codec_ready};
         K_S1:     return bus.ac97_in_slot1;
         K_S2:     return bus.ac97_in_slot2;
         K_VLD:    return {19'b0, bus.ac97_in_valid};
         default:  return 20'hxxxxx;
      endcase
   endfunction

   task automatic push_exp(input int c, input int kind, input logic [19:0] v);
      exp_t e;
      e.cyc  = c;
      e.kind = kind;
      e.val  = v;
      q.push_back(e);
   endtask

   task automatic push_all_zero(input int c);
      for (int k = K_SDATA; k <= K_VLD; k++)
         push_exp(c, k, 20'h0);
   endtask

   // Whole tx frame starting (cnt 0) at cycle f: tag, slots 1..4, then zeros.
   task automatic push_tx_frame(input int f, input logic [15:0] tag,
                                input logic [19:0] s1, input logic [19:0] s2,
                                input logic [19:0] s3, input logic [19:0] s4);
      logic [255:0] fr;
      fr = {tag, s1, s2, s3, s4, 160'b0};
      for (int k = 0; k < 256; k++) begin
         push_exp(f + k, K_SDATA,  {19'b0, fr[255 - k]});
         push_exp(f + k, K_SYNC,   {19'b0, (k <= 14) || (k == 255)});
         push_exp(f + k, K_STROBE, {19'b0, (k == 255)});
      end
   endtask

   // Status outputs around the publish point of the rx frame starting at cycle f.
   task automatic push_rx(input int f, input logic rdy, input logic vld,
                          input logic [19:0] s1, input logic [19:0] s2);
      push_exp(f + 56, K_VLD, 20'h0);
      push_exp(f + 57, K_VLD, {19'b0, vld});
      push_exp(f + 57, K_RDY, {19'b0, rdy});
      push_exp(f + 57, K_S1,  s1);
      push_exp(f + 57, K_S2,  s2);
      push_exp(f + 58, K_VLD, 20'h0);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge ac97_bitclk);
   endtask

   task automatic set_slots(input logic [19:0] s1, input logic v1,
                            input logic [19:0] s2, input logic v2,
                            input logic [19:0] s3, input logic v3,
                            input logic [19:0] s4, input logic v4);
      bus.ac97_out_slot1 = s1;  bus.ac97_out_slot1_valid = v1;
      bus.ac97_out_slot2 = s2;  bus.ac97_out_slot2_valid = v2;
      bus.ac97_out_slot3 = s3;  bus.ac97_out_slot3_valid = v3;
      bus.ac97_out_slot4 = s4;  bus.ac97_out_slot4_valid = v4;
   endtask

   // Monitor: every falling edge, compare all expectations due this cycle.
   always @(negedge ac97_bitclk) begin : monitor
      int          i;
      logic [19:0] act;
      i = 0;
      while (i < q.size()) begin
         if (q[i].cyc <= cyc) begin
            act = observe(q[i].kind);
            n_checks++;
            if (q[i].cyc == cyc && act === q[i].val)
               n_pass++;
            else
               $display("FAIL %s at cycle %0d (now %0d): got %h, want %h",
                        kname(q[i].kind), q[i].cyc, cyc, act, q[i].val);
            q.delete(i);
         end else begin
            i++;
         end
      end
   end

   // Codec model: drives rx frame bit k during the cycle with cnt == k+1.
   logic [255:0] rx_frames [0:4];
   int           rx_f0    = 0;
   bit           codec_en = 1'b0;

   initial begin : codec
      int c;
      int n;
      bus.ac97_sdata_in = 1'b0;
      forever begin
         @(negedge ac97_bitclk);
         bus.ac97_sdata_in = 1'b0;
         if (codec_en && cyc >= rx_f0) begin
            c = (cyc - rx_f0) % 256;
            n = (cyc - rx_f0) / 256;
            if (n <= 4 && c >= 1 && c <= 56)
               bus.ac97_sdata_in = rx_frames[n][256 - c];
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int f0;
      int f1;

      rx_frames[0] = '0;
      rx_frames[1] = {16'hE000, 20'h26000, 20'h000F0, 200'b0};
      rx_frames[2] = {16'h8000, 20'h11111, 20'h22222, 200'b0};
      rx_frames[3] = {16'h6000, 20'h0ABCD, 20'h54321, 200'b0};
      rx_frames[4] = {16'hE000, 20'h13579, 20'h2468A, 200'b0};

      set_slots(20'h0, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge ac97_bitclk);

      // Reset state.
      push_all_zero(cyc + 1);
      @(negedge ac97_bitclk);

      // Frame A: command slots valid, PCM invalid.
      set_slots(20'h02000, 1'b1, 20'h08080, 1'b1, 20'h0, 1'b0, 20'h0, 1'b0);
      rst = 1'b0;
      f0 = cyc + 2;
      push_exp(f0 - 1, K_STROBE, 20'h1);
      push_exp(f0 - 1, K_SYNC,   20'h1);
      push_exp(f0 - 1, K_SDATA,  20'h0);
      push_tx_frame(f0, 16'hE000, 20'h02000, 20'h08080, 20'h0, 20'h0);

      rx_f0    = f0;
      codec_en = 1'b1;
      push_rx(f0,        1'b0, 1'b0, 20'h00000, 20'h00000);
      push_rx(f0 + 256,  1'b1, 1'b1, 20'h26000, 20'h000F0);
      push_rx(f0 + 512,  1'b1, 1'b0, 20'h26000, 20'h000F0);
      push_rx(f0 + 768,  1'b0, 1'b1, 20'h0ABCD, 20'h54321);
      push_rx(f0 + 1024, 1'b1, 1'b1, 20'h13579, 20'h2468A);

      wait_until(f0 - 1);
      n_checks++;
      if (bus.ac97_strobe === 1'b1) n_pass++;
      else $display("FAIL direct strobe after reset release: got %b", bus.ac97_strobe);
      n_checks++;
      if (bus.ac97_sync === 1'b1) n_pass++;
      else $display("FAIL direct sync after reset release: got %b", bus.ac97_sync);
      n_checks++;
      if (bus.ac97_sdata_out === 1'b0) n_pass++;
      else $display("FAIL direct sdata_out after reset release: got %b", bus.ac97_sdata_out);

      // Mid-frame input changes are ignored.
      wait_until(f0 + 100);
      set_slots(20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1);

      // Frame B: PCM slots only, presented during the strobe cycle.
      wait_until(f0 + 255);
      set_slots(20'h0, 1'b0, 20'h0, 1'b0, 20'hABCDE, 1'b1, 20'h12345, 1'b1);
      push_tx_frame(f0 + 256, 16'h9800, 20'h0, 20'h0, 20'hABCDE, 20'h12345);

      wait_until(f0 + 256 + 30);
      set_slots(20'h55555, 1'b1, 20'hAAAAA, 1'b1, 20'h33333, 1'b0, 20'hCCCCC, 1'b0);

      wait_until(f0 + 511);
      set_slots(20'h0, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0);

      // Asynchronous reset in the middle of a frame (cnt 100).
      wait_until(f0 + 1024 + 99);
      push_all_zero(cyc + 1);
      @(posedge ac97_bitclk);
      #2;
      rst      = 1'b1;
      codec_en = 1'b0;
      #1;
      n_checks++;
      if (bus.ac97_sync === 1'b0 && bus.ac97_strobe === 1'b0) n_pass++;
      else $display("FAIL direct sync/strobe after async reset: %b/%b",
                    bus.ac97_sync, bus.ac97_strobe);
      n_checks++;
      if (bus.ac97_sdata_out === 1'b0) n_pass++;
      else $display("FAIL direct sdata_out after async reset: got %b", bus.ac97_sdata_out);
      n_checks++;
      if (bus.ac97_in_valid === 1'b0 && bus.ac97_codec_ready === 1'b0) n_pass++;
      else $display("FAIL direct in_valid/codec_ready after async reset: %b/%b",
                    bus.ac97_in_valid, bus.ac97_codec_ready);
      @(negedge ac97_bitclk);
      repeat (2) @(negedge ac97_bitclk);

      // First post-reset frame: full frame with one-cycle sync lead.
      set_slots(20'h5A5A5, 1'b1, 20'h0, 1'b0, 20'h0, 1'b0, 20'h0, 1'b0);
      rst = 1'b0;
      f1 = cyc + 2;
      push_exp(f1 - 1, K_STROBE, 20'h1);
      push_exp(f1 - 1, K_SYNC,   20'h1);
      push_tx_frame(f1, 16'hC000, 20'h5A5A5, 20'h0, 20'h0, 20'h0);
      push_rx(f1, 1'b0, 1'b0, 20'h0, 20'h0);

      wait_until(f1 + 258);
      @(negedge ac97_bitclk);

      while (q.size() > 0) begin
         n_checks++;
         $display("FAIL %s at cycle %0d: never compared, want %h",
                  kname(q[0].kind), q[0].cyc, q[0].val);
         q.delete(0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
